// File: rtl/fpga_sdram_controller_dmaster_packets_to_bytes.sv
// Debug-master packets-to-bytes framer: expands each Avalon-ST beat into a 0x7A..0x7D framed byte stream.
// Optional channel framing is enabled by defining DMASTER_P2B_CHANNEL_EN.
module fpga_sdram_controller_dmaster_packets_to_bytes #(
   parameter int unsigned CHANNEL_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic                     in_startofpacket,
   input  logic                     in_endofpacket,
   input  logic [CHANNEL_WIDTH-1:0] in_channel,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data
);

   typedef enum logic [2:0] {IDLE, CH, CH_ESC, CH_VAL, SOP, EOP, ESC, DATA} state_t;

   state_t     state_q, state_d, eff;
   logic       need_ch, ch_special, data_special, xfer;
   logic [7:0] ch_byte;

   function automatic logic is_special(input logic [7:0] b);
      return (b >= 8'h7A) && (b <= 8'h7D);
   endfunction

   // Next required step after s; IDLE yields the first step of the beat.
   function automatic state_t next_step(input state_t s, input logic nch, input logic cesc,
                                        input logic sop, input logic eop, input logic desc);
      state_t after_eop, after_sop, after_ch;
      after_eop = desc ? ESC : DATA;
      after_sop = eop ? EOP : after_eop;
      after_ch  = sop ? SOP : after_sop;
      case (s)
         IDLE:    return nch ? CH : after_ch;
         CH:      return cesc ? CH_ESC : CH_VAL;
         CH_ESC:  return CH_VAL;
         CH_VAL:  return after_ch;
         SOP:     return after_sop;
         EOP:     return after_eop;
         ESC:     return DATA;
         default: return IDLE;
      endcase
   endfunction

`ifdef DMASTER_P2B_CHANNEL_EN
   logic [CHANNEL_WIDTH-1:0] last_channel_q, last_channel_d;
   logic                     chan_known_q, chan_known_d;

   assign ch_byte    = 8'(in_channel);
   assign ch_special = is_special(ch_byte);
   assign need_ch    = !chan_known_q || in_startofpacket || (in_channel != last_channel_q);
`else
   logic unused_channel;

   assign unused_channel = ^in_channel;
   assign ch_byte        = '0;
   assign ch_special     = 1'b0;
   assign need_ch        = 1'b0;
`endif

   assign data_special = is_special(in_data);

   always_comb begin
      eff = (state_q == IDLE)
          ? next_step(IDLE, need_ch, ch_special, in_startofpacket, in_endofpacket, data_special)
          : state_q;
      xfer      = in_valid && out_ready && !reset;
      out_valid = in_valid;
      in_ready  = (eff == DATA) && out_ready && !reset;
      case (eff)
         CH:      out_data = 8'h7C;
         CH_ESC:  out_data = 8'h7D;
         CH_VAL:  out_data = ch_special ? (ch_byte ^ 8'h20) : ch_byte;
         SOP:     out_data = 8'h7A;
         EOP:     out_data = 8'h7B;
         ESC:     out_data = 8'h7D;
         DATA:    out_data = data_special ? (in_data ^ 8'h20) : in_data;
         default: out_data = '0;
      endcase
      state_d = state_q;
      if (xfer) begin
         state_d = next_step(eff, need_ch, ch_special, in_startofpacket, in_endofpacket, data_special);
      end
`ifdef DMASTER_P2B_CHANNEL_EN
      last_channel_d = last_channel_q;
      chan_known_d   = chan_known_q;
      if (xfer && (eff == CH_VAL)) begin
         last_channel_d = in_channel;
         chan_known_d   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef DMASTER_P2B_CHANNEL_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         last_channel_q <= '0;
         chan_known_q   <= 1'b0;
      end else begin
         last_channel_q <= last_channel_d;
         chan_known_q   <= chan_known_d;
      end
   end
`endif

endmodule
